// File: rtl/wishbone_master.sv
// Wishbone classic-cycle master: one command becomes N single-beat transfers.
// Define WBM_TIMEOUT_EN to abort a beat after TIMEOUT_CYC cycles without ack.
module wishbone_master #(
    parameter int LEN_W       = 8,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic             cmd_we_i,
    input  logic [31:0]      cmd_adr_i,
    input  logic [3:0]       cmd_sel_i,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic             wr_valid_i,
    output logic             wr_ready_o,
    input  logic [31:0]      wr_data_i,
    output logic             rd_valid_o,
    input  logic             rd_ready_i,
    output logic [31:0]      rd_data_o,
    output logic             done_o,
    output logic             err_o,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic [31:0]      wbm_dat_i,
    input  logic             wbm_ack_i
);

    typedef enum logic [2:0] {IDLE, WDAT, REQ, RDRSP, DONE} state_t;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
`ifdef WBM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    state_t           state, state_n;
    logic [31:0]      adr_n, dat_n, rdat_n;
    logic [3:0]       sel_n;
    logic             we_n, rvld_n, err_n;
    logic [LEN_W-1:0] cnt, cnt_n;
    logic [TW-1:0]    tcnt, tcnt_n;
    logic             timeout;

    // Beat timer restarts whenever REQ is entered; constant-folds away when disabled.
    assign timeout = TO_EN && (tcnt == TW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_n = state;
        adr_n   = wbm_adr_o;
        sel_n   = wbm_sel_o;
        we_n    = wbm_we_o;
        dat_n   = wbm_dat_o;
        rdat_n  = rd_data_o;
        rvld_n  = rd_valid_o;
        err_n   = err_o;
        cnt_n   = cnt;
        tcnt_n  = (state == REQ) ? tcnt + 1'b1 : '0;
        unique case (state)
            IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    adr_n   = cmd_adr_i;
                    sel_n   = cmd_sel_i;
                    we_n    = cmd_we_i;
                    cnt_n   = cmd_len_i;
                    err_n   = 1'b0;
                    state_n = cmd_we_i ? WDAT : REQ;
                end
            end
            WDAT: begin
                if (wr_valid_i && wr_ready_o) begin
                    dat_n   = wr_data_i;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (wbm_ack_i) begin
                    if (!wbm_we_o) begin
                        rdat_n  = wbm_dat_i;
                        rvld_n  = 1'b1;
                        state_n = RDRSP;
                    end else if (cnt != '0) begin
                        adr_n   = wbm_adr_o + 32'd4;
                        cnt_n   = cnt - 1'b1;
                        state_n = WDAT;
                    end else begin
                        state_n = DONE;
                    end
                end else if (timeout) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end
            end
            RDRSP: begin
                if (rd_ready_i) begin
                    rvld_n = 1'b0;
                    if (cnt != '0) begin
                        adr_n   = wbm_adr_o + 32'd4;
                        cnt_n   = cnt - 1'b1;
                        state_n = REQ;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            cmd_ready_o <= 1'b0;
            wr_ready_o  <= 1'b0;
            rd_valid_o  <= 1'b0;
            rd_data_o   <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tcnt        <= tcnt_n;
            // Handshake and bus strobes are registered views of the next state.
            cmd_ready_o <= (state_n == IDLE);
            wr_ready_o  <= (state_n == WDAT);
            done_o      <= (state_n == DONE);
            wbm_stb_o   <= (state_n == REQ);
            wbm_cyc_o   <= (state_n == WDAT) || (state_n == REQ) ||
                           (state_n == RDRSP);
            rd_valid_o  <= rvld_n;
            rd_data_o   <= rdat_n;
            err_o       <= err_n;
            wbm_we_o    <= we_n;
            wbm_sel_o   <= sel_n;
            wbm_adr_o   <= adr_n;
            wbm_dat_o   <= dat_n;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// Scoreboard bench for wishbone_master: stimulus pushes expectations,
// a negedge monitor pops them on bus transfers, read handshakes and done pulses.
module tb_wishbone_master;

    logic        clk, rst_n;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [31:0] cmd_adr;
    logic [3:0]  cmd_sel;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready;
    logic [31:0] rd_data;
    logic        done, err;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_o, dat_i;
    logic        ack;

    logic hang;
    int   dly, w;
    int   tests, fails;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [3:0]  sel;
        logic [31:0] dat;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic        exp_done[$];

    wishbone_master #(.LEN_W(8), .TIMEOUT_CYC(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_we_i(cmd_we), .cmd_adr_i(cmd_adr),
        .cmd_sel_i(cmd_sel), .cmd_len_i(cmd_len),
        .wr_valid_i(wr_valid), .wr_ready_o(wr_ready), .wr_data_i(wr_data),
        .rd_valid_o(rd_valid), .rd_ready_i(rd_ready), .rd_data_o(rd_data),
        .done_o(done), .err_o(err),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we),
        .wbm_sel_o(sel), .wbm_adr_o(adr), .wbm_dat_o(dat_o),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    // Slave: acks dly cycles into a strobe, holding ack across one sampling edge.
    initial begin
        ack = 1'b0; dat_i = '0; w = 0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n) begin
                ack = 1'b0; w = 0;
            end else if (ack) begin
                ack = 1'b0;
            end else if (cyc && stb && !hang) begin
                if (w >= dly) begin
                    ack = 1'b1; dat_i = slv_data(adr); w = 0;
                end else w++;
            end else w = 0;
        end
    end

    // Monitor
    initial begin
        bus_t e;
        logic d;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cyc && stb && ack) begin
                    if (exp_bus.size() == 0) chk("bus_unexp", 1, 0);
                    else begin
                        e = exp_bus.pop_front();
                        chk("bus_we", {31'd0, we}, {31'd0, e.we});
                        chk("bus_adr", adr, e.adr);
                        chk("bus_sel", {28'd0, sel}, {28'd0, e.sel});
                        if (e.we) chk("bus_dat", dat_o, e.dat);
                    end
                end
                if (rd_valid && rd_ready) begin
                    if (exp_rd.size() == 0) chk("rd_unexp", 1, 0);
                    else chk("rd_data", rd_data, exp_rd.pop_front());
                end
                if (done) begin
                    if (exp_done.size() == 0) chk("done_unexp", 1, 0);
                    else begin
                        d = exp_done.pop_front();
                        chk("done_err", {31'd0, err}, {31'd0, d});
                        chk("done_cyc", {31'd0, cyc}, 0);
                    end
                end
                if (wr_ready && rd_valid) chk("wr_rd_excl", 1, 0);
                if (stb && !cyc) chk("stb_no_cyc", 1, 0);
            end
        end
    end

    task automatic send_cmd(input logic w_e, input logic [31:0] a,
                            input logic [3:0] s, input logic [7:0] l);
        int i;
        @(negedge clk); #1;
        cmd_valid = 1'b1; cmd_we = w_e; cmd_adr = a;
        cmd_sel = s; cmd_len = l;
        i = 0;
        while (!cmd_ready && i < 100) begin
            @(negedge clk); #1; i++;
        end
        if (i >= 100) chk("cmd_timeout", 1, 0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input logic [31:0] d, input int gap);
        int i;
        repeat (gap) @(negedge clk);
        #1; wr_valid = 1'b1; wr_data = d;
        i = 0;
        while (!wr_ready && i < 100) begin
            @(negedge clk); #1; i++;
        end
        if (i >= 100) chk("wr_timeout", 1, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(output int stb_cnt, output int cyc_low);
        int i;
        stb_cnt = 0; cyc_low = 0; i = 0;
        @(negedge clk);
        while (!done && i < 300) begin
            if (stb) stb_cnt++;
            if (!cyc) cyc_low++;
            @(negedge clk); i++;
        end
        if (i >= 300) chk("done_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        int sc, cl, i;
        tests = 0; fails = 0;
        rst_n = 1'b0; hang = 1'b0; dly = 2;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0;
        cmd_sel = '0; cmd_len = '0;
        wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;

        #22;
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        chk("rst_cyc", {31'd0, cyc}, 0);
        chk("rst_stb", {31'd0, stb}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid}, 0);
        chk("rst_adr", adr, 0);
        @(negedge clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", {31'd0, cmd_ready}, 1);

        // 1: single read
        exp_bus.push_back('{1'b0, 32'h10, 4'hF, 32'h0});
        exp_rd.push_back(32'hDEADBEEF);
        exp_done.push_back(1'b0);
        send_cmd(1'b0, 32'h10, 4'hF, 8'd0);
        chk("rd_cmd_ready_low", {31'd0, cmd_ready}, 0);
        @(negedge clk);
        chk("rd_stb_latency", {31'd0, stb}, 1);
        wait_done(sc, cl);
        chk("rd_one_stb", sc, 2);

        // 2: 4-beat write, gapped data
        for (int k = 0; k < 4; k++)
            exp_bus.push_back('{1'b1, 32'h100 + 32'(4 * k), 4'h3,
                                32'(k + 1)});
        exp_done.push_back(1'b0);
        send_cmd(1'b1, 32'h100, 4'h3, 8'd3);
        @(negedge clk);
        chk("wr_ready_latency", {31'd0, wr_ready}, 1);
        chk("wr_stb_idle", {31'd0, stb}, 0);
        for (int k = 0; k < 4; k++) push_wr(32'(k + 1), 1);
        wait_done(sc, cl);
        chk("wr_cyc_held", cl, 0);

        // 3: read backpressure
        rd_ready = 1'b0;
        exp_bus.push_back('{1'b0, 32'h200, 4'hF, 32'h0});
        exp_bus.push_back('{1'b0, 32'h204, 4'hF, 32'h0});
        exp_rd.push_back(32'hA5A5_0200);
        exp_rd.push_back(32'hA5A5_0204);
        exp_done.push_back(1'b0);
        send_cmd(1'b0, 32'h200, 4'hF, 8'd1);
        i = 0;
        while (!rd_valid && i < 100) begin
            @(negedge clk); i++;
        end
        if (i >= 100) chk("bp_valid_timeout", 1, 0);
        repeat (5) begin
            @(negedge clk);
            chk("bp_data_hold", rd_data, 32'hA5A5_0200);
            chk("bp_no_stb", {31'd0, stb}, 0);
        end
        @(posedge clk); #1 rd_ready = 1'b1;
        wait_done(sc, cl);

        // 4: address wrap
        exp_bus.push_back('{1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0});
        exp_bus.push_back('{1'b0, 32'h0000_0000, 4'hF, 32'h0});
        exp_rd.push_back(32'h5A5A_FFFC);
        exp_rd.push_back(32'hA5A5_0000);
        exp_done.push_back(1'b0);
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 8'd1);
        wait_done(sc, cl);

        // 5: reset while strobing
        hang = 1'b1;
        send_cmd(1'b0, 32'h40, 4'hF, 8'd0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_cyc", {31'd0, cyc}, 0);
        chk("mid_rst_stb", {31'd0, stb}, 0);
        chk("mid_rst_rd_valid", {31'd0, rd_valid}, 0);
        @(negedge clk); #1 rst_n = 1'b1; hang = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", {31'd0, cmd_ready}, 1);
        exp_bus.push_back('{1'b0, 32'h80, 4'h5, 32'h0});
        exp_rd.push_back(32'hA5A5_0080);
        exp_done.push_back(1'b0);
        send_cmd(1'b0, 32'h80, 4'h5, 8'd0);
        wait_done(sc, cl);

`ifdef WBM_TIMEOUT_EN
        // 6: ack never arrives
        hang = 1'b1;
        exp_done.push_back(1'b1);
        send_cmd(1'b0, 32'h300, 4'hF, 8'd2);
        wait_done(sc, cl);
        chk("to_stb_cycles", sc, 8);
        chk("to_err_sticky", {31'd0, err}, 1);
        hang = 1'b0;
        exp_bus.push_back('{1'b0, 32'h300, 4'hF, 32'h0});
        exp_rd.push_back(32'hA5A5_0300);
        exp_done.push_back(1'b0);
        send_cmd(1'b0, 32'h300, 4'hF, 8'd0);
        chk("to_err_clear", {31'd0, err}, 0);
        wait_done(sc, cl);
`endif

        repeat (3) @(negedge clk);
        chk("bus_q_empty", exp_bus.size(), 0);
        chk("rd_q_empty", exp_rd.size(), 0);
        chk("done_q_empty", exp_done.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
